// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit AND/OR/ADD/COMPARE through one
// 1-bit ALU slice (alu_top), LSB first, with the ripple carry kept in a flop.

module alu_top (
   input  logic       src1_i,
   input  logic       src2_i,
   input  logic       less_i,
   input  logic       equal_i,
   input  logic       aInvert_i,
   input  logic       bInvert_i,
   input  logic       cin_i,
   input  logic [1:0] operation_i,
   input  logic [2:0] comp_i,
   output logic       result_o,
   output logic       cout_o
);

   logic a;
   logic b;
   logic cmpRes;

   assign a      = src1_i ^ aInvert_i;
   assign b      = src2_i ^ bInvert_i;
   assign cout_o = (a & b) | (cin_i & (a ^ b));

   always_comb begin
      cmpRes = 1'b0;
      case (comp_i)
         3'b000:  cmpRes = less_i;
         3'b001:  cmpRes = ~less_i & ~equal_i;
         3'b010:  cmpRes = less_i | equal_i;
         3'b011:  cmpRes = ~less_i;
         3'b110:  cmpRes = equal_i;
         3'b100:  cmpRes = ~equal_i;
         default: cmpRes = 1'b0;
      endcase
   end

   always_comb begin
      result_o = 1'b0;
      case (operation_i)
         2'b00: result_o = a & b;
         2'b01: result_o = a | b;
         2'b10: result_o = a ^ b ^ cin_i;
         2'b11: result_o = cmpRes;
      endcase
   end

endmodule

module alu_serial_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       ctrl_i,
   input  logic [2:0]       comp_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {IDLE, RUN, CMP} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   aSh_q, aSh_d, bSh_q, bSh_d, res_q, res_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         ctrl_q, ctrl_d;
   logic [2:0]         comp_q, comp_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d, orAcc_q, orAcc_d;
   logic               cMsbIn_q, cMsbIn_d, cMsbOut_q, cMsbOut_d;
   logic               zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

   logic               isCmp, lastBit;
   logic               sA, sB, sLess, sEqual, sAinv, sBinv, sRes, sCout;
   logic [1:0]         sOp;

   assign isCmp   = (ctrl_q[1:0] == 2'b11);
   assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));

   alu_top slice (
      .src1_i      (sA),
      .src2_i      (sB),
      .less_i      (sLess),
      .equal_i     (sEqual),
      .aInvert_i   (sAinv),
      .bInvert_i   (sBinv),
      .cin_i       (carry_q),
      .operation_i (sOp),
      .comp_i      (comp_q),
      .result_o    (sRes),
      .cout_o      (sCout)
   );

   // A compare runs its serial pass as A - B, then one extra slice cycle on the
   // less/equal path with less = sign ^ overflow of that difference.
   always_comb begin
      sA     = 1'b0;
      sB     = 1'b0;
      sLess  = 1'b0;
      sEqual = 1'b0;
      sAinv  = 1'b0;
      sBinv  = 1'b0;
      sOp    = 2'b00;
      if (state_q == RUN) begin
         sA    = aSh_q[0];
         sB    = bSh_q[0];
         sAinv = isCmp ? 1'b0 : ctrl_q[3];
         sBinv = isCmp ? 1'b1 : ctrl_q[2];
         sOp   = isCmp ? 2'b10 : ctrl_q[1:0];
      end else if (state_q == CMP) begin
         sOp    = 2'b11;
         sLess  = res_q[WIDTH-1] ^ cMsbIn_q ^ cMsbOut_q;
         sEqual = ~orAcc_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      aSh_d     = aSh_q;
      bSh_d     = bSh_q;
      res_d     = res_q;
      ctrl_d    = ctrl_q;
      comp_d    = comp_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      orAcc_d   = orAcc_q;
      cMsbIn_d  = cMsbIn_q;
      cMsbOut_d = cMsbOut_q;
      result_d  = result_q;
      zero_d    = zero_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               aSh_d   = src1_i;
               bSh_d   = src2_i;
               ctrl_d  = ctrl_i;
               comp_d  = comp_i;
               carry_d = (ctrl_i[1:0] == 2'b11) ? 1'b1 : ctrl_i[2];
               cnt_d   = '0;
               orAcc_d = 1'b0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d   = {sRes, res_q[WIDTH-1:1]};
            aSh_d   = aSh_q >> 1;
            bSh_d   = bSh_q >> 1;
            carry_d = sCout;
            orAcc_d = orAcc_q | sRes;
            cnt_d   = cnt_q + CNT_W'(1);
            if (lastBit) begin
               cMsbIn_d  = carry_q;
               cMsbOut_d = sCout;
               if (isCmp) begin
                  state_d = CMP;
               end else begin
                  result_d = res_d;
                  zero_d   = ~orAcc_d;
                  cout_d   = (ctrl_q[1:0] == 2'b10) ? sCout : 1'b0;
                  ovf_d    = (ctrl_q[1:0] == 2'b10) ? (carry_q ^ sCout) : 1'b0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         CMP: begin
            result_d = {{(WIDTH-1){1'b0}}, sRes};
            zero_d   = ~sRes;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         aSh_q     <= '0;
         bSh_q     <= '0;
         res_q     <= '0;
         ctrl_q    <= '0;
         comp_q    <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         orAcc_q   <= 1'b0;
         cMsbIn_q  <= 1'b0;
         cMsbOut_q <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         aSh_q     <= aSh_d;
         bSh_q     <= bSh_d;
         res_q     <= res_d;
         ctrl_q    <= ctrl_d;
         comp_q    <= comp_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         orAcc_q   <= orAcc_d;
         cMsbIn_q  <= cMsbIn_d;
         cMsbOut_q <= cMsbOut_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign result_o   = result_q;
   assign zero_o     = zero_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq (WIDTH=32): arithmetic, logic, compare,
// handshake and reset-abort scenarios with hand-computed expectations.

module tb_alu_serial_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] src1, src2;
   logic [3:0]  ctrl;
   logic [2:0]  comp;
   logic [31:0] result;
   logic        zero, cout, overflow, busy, done;

   int vectors     = 0;
   int miscompares = 0;
   int cycles;
   int doneSeen;

   alu_serial_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .src1_i     (src1),
      .src2_i     (src2),
      .ctrl_i     (ctrl),
      .comp_i     (comp),
      .result_o   (result),
      .zero_o     (zero),
      .cout_o     (cout),
      .overflow_o (overflow),
      .busy_o     (busy),
      .done_o     (done)
   );

   always #5 clk = ~clk;

   // Flags packed as {zero, cout, overflow, busy, done}.
   function automatic logic [31:0] flags();
      return {27'b0, zero, cout, overflow, busy, done};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulses start for one edge, then counts cycles until done_o (bounded).
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] c, input logic [2:0] cm,
                                output int cyc);
      @(negedge clk);
      src1 = a; src2 = b; ctrl = c; comp = cm; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; src1 = ~a; src2 = ~b; ctrl = ~c; comp = ~cm;
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (done) break;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; ctrl = '0; comp = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_result", result, 32'h0);
      checkOutput("reset_flags", flags(), 32'h0);
      rst = 1'b0;

      applyStimulus(32'h7FFFFFFF, 32'h00000001, 4'b0010, 3'b000, cycles);
      checkOutput("add_latency", cycles, 32);
      checkOutput("add_result", result, 32'h80000000);
      checkOutput("add_flags", flags(), 32'b00101);
      @(negedge clk);
      checkOutput("done_one_cycle", {31'b0, done}, 32'h0);

      applyStimulus(32'd5, 32'd5, 4'b0110, 3'b000, cycles);
      checkOutput("sub_result", result, 32'h0);
      checkOutput("sub_flags", flags(), 32'b11001);

      applyStimulus(32'hF0F0F0F0, 32'h0F0F0000, 4'b1100, 3'b000, cycles);
      checkOutput("nor_result", result, 32'h00000F0F);
      checkOutput("nor_flags", flags(), 32'b00001);

      applyStimulus(32'h0000F000, 32'h000000F0, 4'b0001, 3'b000, cycles);
      checkOutput("or_result", result, 32'h0000F0F0);

      applyStimulus(32'hFFFFFFFD, 32'd2, 4'b0011, 3'b000, cycles);
      checkOutput("cmp_latency", cycles, 33);
      checkOutput("cmp_lt_result", result, 32'd1);
      checkOutput("cmp_lt_flags", flags(), 32'b00001);

      applyStimulus(32'hFFFFFFFD, 32'd2, 4'b0011, 3'b001, cycles);
      checkOutput("cmp_gt_result", result, 32'd0);
      checkOutput("cmp_gt_flags", flags(), 32'b10001);

      applyStimulus(32'd7, 32'd7, 4'b0011, 3'b110, cycles);
      checkOutput("cmp_eq_result", result, 32'd1);

      applyStimulus(32'd7, 32'd7, 4'b0011, 3'b100, cycles);
      checkOutput("cmp_ne_result", result, 32'd0);

      applyStimulus(32'd2, 32'hFFFFFFFD, 4'b0011, 3'b011, cycles);
      checkOutput("cmp_ge_result", result, 32'd1);

      applyStimulus(32'hFFFFFFFD, 32'hFFFFFFFD, 4'b0011, 3'b010, cycles);
      checkOutput("cmp_le_result", result, 32'd1);

      applyStimulus(32'h80000000, 32'd1, 4'b0011, 3'b000, cycles);
      checkOutput("cmp_ovf_result", result, 32'd1);

      // Handshake: start held high across two operations with changing operands.
      @(negedge clk);
      src1 = 32'd10; src2 = 32'd3; ctrl = 4'b0010; comp = 3'b000; start = 1'b1;
      for (int k = 0; k <= 32; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 5) checkOutput("hs_busy_mid", {31'b0, busy}, 32'h1);
         if (k < 32) begin
            src1 = k; src2 = 32'd1000;
         end else begin
            checkOutput("hs_first_done", {31'b0, done}, 32'h1);
            checkOutput("hs_first_result", result, 32'd13);
            src1 = 32'h1234; src2 = 32'h1111;
         end
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("hs_second_busy", {31'b0, busy}, 32'h1);
      src1 = 32'hDEAD; src2 = 32'hBEEF;
      repeat (6) @(negedge clk);
      checkOutput("hs_result_hold", result, 32'd13);
      start = 1'b0;
      cycles = 0;
      while (cycles < 100) begin
         @(posedge clk);
         @(negedge clk);
         cycles++;
         if (done) break;
      end
      checkOutput("hs_second_latency", cycles, 26);
      checkOutput("hs_second_result", result, 32'h2345);

      // Reset in the middle of a RUN aborts with no completion pulse.
      @(negedge clk);
      src1 = 32'd100; src2 = 32'd1; ctrl = 4'b0110; comp = 3'b000; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_result", result, 32'h0);
      checkOutput("abort_flags", flags(), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("abort_no_done", doneSeen, 0);

      applyStimulus(32'd100, 32'd1, 4'b0110, 3'b000, cycles);
      checkOutput("post_reset_latency", cycles, 32);
      checkOutput("post_reset_result", result, 32'd99);
      checkOutput("post_reset_flags", flags(), 32'b01001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer that computes a full WIDTH-bit ALU operation using one instance of the team's 1-bit ALU slice (alu_top).
- Latches both operands, then clocks them through the slice LSB-first, one bit per cycle, and carries the ripple carry in a flop between cycles.
- For compare operations, it adds one cycle that feeds the slice's less/equal/comp path.
- Sits between the core controller and the slice as a low-area ALU option; start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, 6, bit counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- src1_i  input  WIDTH  operand A
- src2_i  input  WIDTH  operand B
- ctrl_i  input  4  [3]=A_invert, [2]=B_invert, [1:0]=operation (00 AND, 01 OR, 10 ADD, 11 COMPARE)
- comp_i  input  3  compare code: 000 lt, 001 gt, 010 le, 011 ge, 110 eq, 100 ne (signed)
- result_o  output  WIDTH  registered result
- zero_o  output  1  result_o == 0
- cout_o  output  1  final carry out (ADD only, else 0)
- overflow_o  output  1  signed overflow (ADD only, else 0)
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_i=1): state=IDLE, all outputs 0, internal shift registers, carry and counter cleared. A reset mid-operation aborts the operation with no done_o.
- States: IDLE, RUN, CMP.
- IDLE -> RUN on start_i=1 (call this edge 0).
  - Latch src1_i, src2_i, ctrl_i, comp_i.
  - Set carry = ctrl_i[2] (B_invert).
  - Clear the counter; busy_o=1.
- RUN, edges 1..WIDTH: slice processes bit k=cnt.
  - Drive: src1=A[0], src2=B[0], A_invert/B_invert/operation from the latched ctrl, cin=carry, less=0, equal=0, comp=latched comp.
  - Capture slice.result into the result shift register MSB side, then shift A and B right.
  - Carry <= slice.cout.
  - Running OR of result bits feeds the zero flag.
  - At bit WIDTH-1, record c_msb_in=carry (before update) and c_msb_out=slice.cout.
- End of RUN (edge WIDTH):
  - If op != 11: result_o <= shifted result; zero_o updated; done_o=1; busy_o=0; state -> IDLE.
    - For op=10: cout_o <= c_msb_out and overflow_o <= c_msb_in ^ c_msb_out.
    - For other ops, cout_o and overflow_o are 0.
  - If op = 11: the RUN pass is forced to subtract (A_invert=0, B_invert=1, operation=10, initial carry 1), regardless of latched ctrl[3:2]; state -> CMP.
- CMP (edge WIDTH+1): drive the slice with operation=11, less=sign^ovf (sign = MSB of difference, ovf = c_msb_in^c_msb_out), equal=(difference==0), comp=latched comp.
  - result_o <= {WIDTH-1 zeros, slice.result}.
  - zero_o updated from that result; cout_o=0; overflow_o=0; done_o=1; busy_o=0; state -> IDLE.
- Latency: done_o is high in the cycle after edge WIDTH (logic ops) or edge WIDTH+1 (compare). busy_o is high from after edge 0 until done_o rises.
- done_o is high for exactly one cycle. result_o and the flags hold until the next operation completes; they do not change during RUN.
- start_i while busy is ignored. No queueing; operand inputs are don't-care while busy.
- Back-to-back: start_i=1 in the done_o cycle is accepted, since state is IDLE.
- Undefined comp_i codes give whatever the slice produces; no special handling.

Test Plan (WIDTH=32):
- ADD: ctrl=0010, A=0x7FFFFFFF, B=0x00000001, start pulse -> done_o 32 cycles after start edge; result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0.
- SUB: ctrl=0110, A=5, B=5 -> result_o=0, zero_o=1, cout_o=1, overflow_o=0. NOR: ctrl=1100, A=0xF0F0F0F0, B=0x0F0F0000 -> result_o=0x00000F0F.
- Compare: ctrl=0011, comp=000, A=0xFFFFFFFD (-3), B=2 -> done 33 cycles after start, result_o=1. Same operands with comp=001 -> result_o=0; A=B=7 with comp=110 -> result_o=1.
- Overflowing compare: comp=000, A=0x80000000, B=1 -> result_o=1 (less = sign^ovf, not raw sign).
- Handshake: start_i held high for 40 cycles with changing operands -> first op completes with the latched operands; a second op starts in the done cycle; busy_o never drops between the two ops.
- Reset: assert rst_i at cycle 10 of a RUN -> all outputs 0 immediately, no done_o; a new start after release completes correctly.
